exec_sequencer: RTL and testbench

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/exec_sequencer_pkg.sv | 18 +
 rtl/exec_sequencer_mem_port.sv | 28 ++
 rtl/exec_sequencer.sv | 113 +++++++++++
 tb/tb_exec_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: state encoding and
// default values for the halt word and the done timeout.
package exec_sequencer_pkg;

    localparam logic [15:0] HALT_INST_DEFAULT    = 16'hFFFF;
    localparam logic [7:0]  DONE_TIMEOUT_DEFAULT = 8'd64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_EXEC,
        ST_WAIT,
        ST_HALT,
        ST_FAULT
    } seq_state_t;

endpackage

// File: rtl/exec_sequencer_mem_port.sv
// Shared memory port multiplexer: instruction fetch address or a granted
// datapath access; quiescent (read of address 0) otherwise.
module mem_port_mux (
    input  logic        fetch_sel,
    input  logic [7:0]  pc,
    input  logic        dp_sel,
    input  logic        dp_rw,
    input  logic [7:0]  dp_addr,
    input  logic [15:0] dp_wdata,
    output logic [7:0]  mem_addr,
    output logic        mem_rw,
    output logic [15:0] mem_wdata
);

    always_comb begin
        mem_addr  = '0;
        mem_rw    = 1'b0;
        mem_wdata = '0;
        if (dp_sel) begin
            mem_addr  = dp_addr;
            mem_rw    = dp_rw;
            mem_wdata = dp_wdata;
        end else if (fetch_sel) begin
            mem_addr = pc;
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Fetch/launch/wait sequencer between the CPU top and its instruction
// interpreter, with retire counter, done timeout and sticky halt/fault.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter logic [15:0] HALT_INST    = HALT_INST_DEFAULT,
    parameter logic [7:0]  DONE_TIMEOUT = DONE_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  pc,
    input  logic [15:0] mem_rdata,
    output logic [7:0]  mem_addr,
    output logic        mem_rw,
    output logic [15:0] mem_wdata,
    input  logic        dp_req,
    input  logic        dp_rw,
    input  logic [7:0]  dp_addr,
    input  logic [15:0] dp_wdata,
    output logic        dp_gnt,
    output logic [15:0] inst,
    output logic        start,
    input  logic        done,
    output logic [7:0]  count,
    output logic        halted,
    output logic        fault
);

    seq_state_t  state;
    seq_state_t  state_next;
    logic [7:0]  tmo;
    logic        timeout_hit;
    logic        fetch_sel;

    // tmo counts EXEC/WAIT cycles from 0, so DONE_TIMEOUT-1 marks the last allowed cycle
    assign timeout_hit = (tmo == DONE_TIMEOUT - 8'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            inst  <= '0;
            count <= '0;
            tmo   <= '0;
        end else begin
            state <= state_next;
            if (state == ST_LATCH) begin
                inst <= mem_rdata;
            end
            if (state == ST_WAIT && done) begin
                count <= count + 8'd1;
            end
            if (state == ST_LATCH) begin
                tmo <= '0;
            end else if (state == ST_EXEC || state == ST_WAIT) begin
                tmo <= tmo + 8'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        dp_gnt     = 1'b0;
        fetch_sel  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                fetch_sel  = 1'b1;
                state_next = ST_LATCH;
            end
            ST_LATCH: begin
                state_next = (mem_rdata == HALT_INST) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                start      = 1'b1;
                state_next = timeout_hit ? ST_FAULT : ST_WAIT;
            end
            ST_WAIT: begin
                dp_gnt = dp_req;
                // a done arriving on the timeout cycle still retires the instruction
                if (done) begin
                    state_next = enable ? ST_FETCH : ST_IDLE;
                end else if (timeout_hit) begin
                    state_next = ST_FAULT;
                end
            end
            ST_HALT:  state_next = ST_HALT;
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign halted = (state == ST_HALT);
    assign fault  = (state == ST_FAULT);

    mem_port_mux u_mem_port_mux (
        .fetch_sel (fetch_sel),
        .pc        (pc),
        .dp_sel    (dp_gnt),
        .dp_rw     (dp_rw),
        .dp_addr   (dp_addr),
        .dp_wdata  (dp_wdata),
        .mem_addr  (mem_addr),
        .mem_rw    (mem_rw),
        .mem_wdata (mem_wdata)
    );

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer.
module tb_exec_sequencer;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [7:0]  pc;
    logic [15:0] mem_rdata;
    logic [7:0]  mem_addr;
    logic        mem_rw;
    logic [15:0] mem_wdata;
    logic        dp_req;
    logic        dp_rw;
    logic [7:0]  dp_addr;
    logic [15:0] dp_wdata;
    logic        dp_gnt;
    logic [15:0] inst;
    logic        start;
    logic        done;
    logic [7:0]  count;
    logic        halted;
    logic        fault;

    int checks;
    int errors;

    exec_sequencer #(
        .HALT_INST    (16'hFFFF),
        .DONE_TIMEOUT (8'd64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .pc        (pc),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_rw    (mem_rw),
        .mem_wdata (mem_wdata),
        .dp_req    (dp_req),
        .dp_rw     (dp_rw),
        .dp_addr   (dp_addr),
        .dp_wdata  (dp_wdata),
        .dp_gnt    (dp_gnt),
        .inst      (inst),
        .start     (start),
        .done      (done),
        .count     (count),
        .halted    (halted),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b1; done = 1'b1; dp_req = 1'b1;
        tick; tick;
        reset = 1'b0; enable = 1'b0; done = 1'b0; dp_req = 1'b0;
        settle;
        checks++; if (inst !== 16'h0000) begin errors++; $display("FAIL rst_inst: got %h expected 0000", inst); end
        checks++; if (count !== 8'h00) begin errors++; $display("FAIL rst_count: got %h expected 00", count); end
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL rst_start: got %b expected 0", start); end
        checks++; if (dp_gnt !== 1'b0) begin errors++; $display("FAIL rst_dp_gnt: got %b expected 0", dp_gnt); end
        checks++; if (mem_rw !== 1'b0) begin errors++; $display("FAIL rst_mem_rw: got %b expected 0", mem_rw); end
        checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL rst_mem_addr: got %h expected 00", mem_addr); end
        checks++; if (mem_wdata !== 16'h0000) begin errors++; $display("FAIL rst_mem_wdata: got %h expected 0000", mem_wdata); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b expected 0", halted); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b expected 0", fault); end
        dp_req = 1'b1;
        settle;
        checks++; if (dp_gnt !== 1'b0) begin errors++; $display("FAIL idle_dp_gnt: got %b expected 0", dp_gnt); end
        dp_req = 1'b0;
        tick;
        checks++; if (start !== 1'b0 || mem_addr !== 8'h00) begin errors++; $display("FAIL idle_stays: start=%b mem_addr=%h expected 0/00", start, mem_addr); end
    endtask

    task automatic test_fetch_latency;
        enable = 1'b1; pc = 8'h04;
        dp_req = 1'b1; dp_rw = 1'b1; dp_addr = 8'h80; dp_wdata = 16'hBEEF;
        tick;
        settle;
        checks++; if (mem_addr !== 8'h04) begin errors++; $display("FAIL fetch_addr: got %h expected 04", mem_addr); end
        checks++; if (mem_rw !== 1'b0) begin errors++; $display("FAIL fetch_rw: got %b expected 0", mem_rw); end
        checks++; if (dp_gnt !== 1'b0) begin errors++; $display("FAIL fetch_dp_gnt: got %b expected 0", dp_gnt); end
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL fetch_start: got %b expected 0", start); end
        dp_req = 1'b0;
        tick;
        mem_rdata = 16'h1234;
        settle;
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL latch_start: got %b expected 0", start); end
        tick;
        enable = 1'b0;
        settle;
        checks++; if (start !== 1'b1) begin errors++; $display("FAIL exec_start: got %b expected 1", start); end
        checks++; if (inst !== 16'h1234) begin errors++; $display("FAIL exec_inst: got %h expected 1234", inst); end
        mem_rdata = 16'h5555;
        tick;
        settle;
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL wait_start: got %b expected 0", start); end
        checks++; if (inst !== 16'h1234) begin errors++; $display("FAIL inst_hold: got %h expected 1234", inst); end
    endtask

    task automatic test_mem_port;
        dp_req = 1'b1; dp_rw = 1'b1; dp_addr = 8'h80; dp_wdata = 16'hBEEF;
        settle;
        checks++; if (dp_gnt !== 1'b1) begin errors++; $display("FAIL dp_gnt_wait: got %b expected 1", dp_gnt); end
        checks++; if (mem_rw !== 1'b1) begin errors++; $display("FAIL dp_mem_rw: got %b expected 1", mem_rw); end
        checks++; if (mem_addr !== 8'h80) begin errors++; $display("FAIL dp_mem_addr: got %h expected 80", mem_addr); end
        checks++; if (mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL dp_mem_wdata: got %h expected beef", mem_wdata); end
        dp_rw = 1'b0; dp_addr = 8'h33;
        settle;
        checks++; if (mem_rw !== 1'b0 || mem_addr !== 8'h33) begin errors++; $display("FAIL dp_read: rw=%b addr=%h expected 0/33", mem_rw, mem_addr); end
        dp_req = 1'b0;
        settle;
        checks++; if (dp_gnt !== 1'b0 || mem_addr !== 8'h00) begin errors++; $display("FAIL dp_release: gnt=%b addr=%h expected 0/00", dp_gnt, mem_addr); end
        done = 1'b1;
        tick;
        done = 1'b0;
        settle;
        checks++; if (count !== 8'd1) begin errors++; $display("FAIL retire_count: got %0d expected 1", count); end
        tick;
        settle;
        checks++; if (mem_addr !== 8'h00 || start !== 1'b0) begin errors++; $display("FAIL stop_at_boundary: addr=%h start=%b expected 00/0", mem_addr, start); end
    endtask

    task automatic test_back_to_back;
        done = 1'b1; enable = 1'b1;
        tick;
        for (int k = 0; k < 3; k++) begin
            pc = 8'h10 + 8'(k);
            settle;
            checks++; if (mem_addr !== 8'h10 + 8'(k)) begin errors++; $display("FAIL b2b_fetch_addr%0d: got %h expected %h", k, mem_addr, 8'h10 + 8'(k)); end
            tick;
            mem_rdata = 16'hA000 + 16'(k);
            tick;
            settle;
            checks++; if (start !== 1'b1 || inst !== 16'hA000 + 16'(k)) begin errors++; $display("FAIL b2b_start%0d: start=%b inst=%h expected 1/%h", k, start, inst, 16'hA000 + 16'(k)); end
            if (k == 2) enable = 1'b0;
            tick;
            settle;
            checks++; if (start !== 1'b0) begin errors++; $display("FAIL b2b_width%0d: got %b expected 0", k, start); end
            tick;
        end
        done = 1'b0;
        settle;
        checks++; if (count !== 8'd4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", count); end
    endtask

    task automatic test_timeout;
        logic early;
        // done delivered on the 64th EXEC/WAIT cycle: retires
        enable = 1'b1; mem_rdata = 16'h2222;
        tick; enable = 1'b0;
        tick; tick;
        early = 1'b0;
        for (int i = 2; i <= 64; i++) begin
            tick; settle;
            if (fault !== 1'b0) early = 1'b1;
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL tmo_early_a: got %b expected 0", early); end
        done = 1'b1;
        tick;
        done = 1'b0;
        settle;
        checks++; if (count !== 8'd5 || fault !== 1'b0) begin errors++; $display("FAIL tmo_done_wins: count=%0d fault=%b expected 5/0", count, fault); end
        // done withheld: fault after the 64th cycle
        enable = 1'b1;
        tick; enable = 1'b0;
        tick; tick;
        early = 1'b0;
        for (int i = 2; i <= 64; i++) begin
            tick; settle;
            if (fault !== 1'b0) early = 1'b1;
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL tmo_early_b: got %b expected 0", early); end
        tick; settle;
        checks++; if (fault !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL tmo_fault: fault=%b halted=%b expected 1/0", fault, halted); end
        early = 1'b0;
        for (int i = 0; i < 6; i++) begin
            enable = i[0]; done = 1'b1; dp_req = 1'b1;
            tick; settle;
            if (fault !== 1'b1 || start !== 1'b0 || dp_gnt !== 1'b0 || count !== 8'd5) early = 1'b1;
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL fault_absorbing: got %b expected 0", early); end
        reset = 1'b1;
        tick;
        reset = 1'b0; done = 1'b0; dp_req = 1'b0; enable = 1'b0;
        settle;
        checks++; if (fault !== 1'b0 || count !== 8'd0) begin errors++; $display("FAIL fault_reset: fault=%b count=%0d expected 0/0", fault, count); end
    endtask

    task automatic test_wrap;
        done = 1'b1; enable = 1'b1; mem_rdata = 16'h0001;
        tick;
        for (int r = 1; r <= 255; r++) begin
            tick; tick; tick; tick;
        end
        settle;
        checks++; if (count !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d expected 255", count); end
        tick; tick; tick; tick;
        settle;
        checks++; if (count !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d expected 0", count); end
        done = 1'b0; mem_rdata = 16'h4321;
        tick; tick; tick;
        reset = 1'b1; done = 1'b1; enable = 1'b1;
        dp_req = 1'b1; dp_rw = 1'b1; dp_addr = 8'h80; dp_wdata = 16'hBEEF;
        tick;
        reset = 1'b0; done = 1'b0; enable = 1'b0;
        settle;
        checks++; if (inst !== 16'h0000) begin errors++; $display("FAIL midwait_inst: got %h expected 0000", inst); end
        checks++; if (count !== 8'd0) begin errors++; $display("FAIL midwait_count: got %0d expected 0", count); end
        checks++; if (start !== 1'b0 || dp_gnt !== 1'b0 || mem_rw !== 1'b0) begin errors++; $display("FAIL midwait_ctl: start=%b gnt=%b rw=%b expected 0/0/0", start, dp_gnt, mem_rw); end
        checks++; if (mem_addr !== 8'h00 || mem_wdata !== 16'h0000) begin errors++; $display("FAIL midwait_bus: addr=%h wdata=%h expected 00/0000", mem_addr, mem_wdata); end
        checks++; if (halted !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL midwait_flags: halted=%b fault=%b expected 0/0", halted, fault); end
        dp_req = 1'b0;
    endtask

    task automatic test_halt;
        logic bad;
        enable = 1'b1; done = 1'b0; mem_rdata = 16'h1111;
        tick; tick; tick; tick;
        done = 1'b1;
        tick;
        done = 1'b0;
        tick;
        mem_rdata = 16'hFFFF;
        settle;
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL halt_latch_start: got %b expected 0", start); end
        tick; settle;
        checks++; if (halted !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL halt_flag: halted=%b fault=%b expected 1/0", halted, fault); end
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL halt_no_start: got %b expected 0", start); end
        checks++; if (count !== 8'd1) begin errors++; $display("FAIL halt_count: got %0d expected 1", count); end
        checks++; if (inst !== 16'hFFFF) begin errors++; $display("FAIL halt_inst: got %h expected ffff", inst); end
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            enable = i[0]; done = 1'b1; mem_rdata = 16'h1234;
            tick; settle;
            if (halted !== 1'b1 || start !== 1'b0 || count !== 8'd1 || mem_addr !== 8'h00) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL halt_absorbing: got %b expected 0", bad); end
        done = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; enable = 1'b0; pc = 8'h00; mem_rdata = 16'h0000;
        dp_req = 1'b0; dp_rw = 1'b0; dp_addr = 8'h00; dp_wdata = 16'h0000; done = 1'b0;
        test_reset;
        test_fetch_latency;
        test_mem_port;
        test_back_to_back;
        test_timeout;
        test_wrap;
        test_halt;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
